imem_loader: RTL and testbench

Boot-time writer for the instruction memory that the pipelined MIPS core fetches from. It accepts a program image as a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words. It issues one write strobe per word to the memory's write port and holds the core in reset until the image is complete. It sits between the bench or host link and the top-level core/imem pair, and is the producer side of the fetch path.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Accepts a byte stream (valid/ready), packs bytes big-endian into 32-bit
// words, issues one write strobe per word and holds the core in reset until
// the whole image has been written. Any malformed image ends in a terminal
// error state that keeps the core in reset.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          byte_idx_reg, byte_idx_next;
    logic [23:0]         shift_reg, shift_next;
    logic                last_reg, last_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   waddr_reg, waddr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic                cpu_reset_reg, cpu_reset_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [ADDR_W:0]     word_count_reg, word_count_next;

    logic                accept;
    logic [ADDR_W:0]     count_inc;

    // Only the LOAD state takes bytes; everything else back-pressures.
    assign s_ready   = (state_reg == LOAD);
    assign accept    = s_valid && (state_reg == LOAD);
    // The extra top bit of the incremented count flags a full memory.
    assign count_inc = word_count_reg + {{ADDR_W{1'b0}}, 1'b1};

    assign we         = we_reg;
    assign waddr      = waddr_reg;
    assign wdata      = wdata_reg;
    assign cpu_reset  = cpu_reset_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign word_count = word_count_reg;

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            byte_idx_reg   <= 2'd0;
            shift_reg      <= 24'd0;
            last_reg       <= 1'b0;
            we_reg         <= 1'b0;
            waddr_reg      <= '0;
            wdata_reg      <= 32'd0;
            cpu_reset_reg  <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            word_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            byte_idx_reg   <= byte_idx_next;
            shift_reg      <= shift_next;
            last_reg       <= last_next;
            we_reg         <= we_next;
            waddr_reg      <= waddr_next;
            wdata_reg      <= wdata_next;
            cpu_reset_reg  <= cpu_reset_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            word_count_reg <= word_count_next;
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_next      = state_reg;
        byte_idx_next   = byte_idx_reg;
        shift_next      = shift_reg;
        last_next       = last_reg;
        we_next         = 1'b0;
        waddr_next      = waddr_reg;
        wdata_next      = wdata_reg;
        cpu_reset_next  = cpu_reset_reg;
        done_next       = done_reg;
        err_next        = err_reg;
        word_count_next = word_count_reg;

        case (state_reg)
            IDLE: begin
                state_next = LOAD;
            end

            LOAD: begin
                if (accept) begin
                    shift_next    = {shift_reg[15:0], s_data};
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        // Fourth byte completes the word: strobe it next cycle.
                        wdata_next = {shift_reg, s_data};
                        waddr_next = word_count_reg[ADDR_W-1:0];
                        we_next    = 1'b1;
                        last_next  = s_last;
                        state_next = WRITE;
                    end else if (s_last) begin
                        // Image ends mid-word: drop the partial word.
                        err_next   = 1'b1;
                        state_next = ERR;
                    end
                end
            end

            WRITE: begin
                word_count_next = count_inc;
                if (last_reg) begin
                    done_next      = 1'b1;
                    cpu_reset_next = 1'b0;
                    state_next     = DONE;
                end else if (count_inc[ADDR_W]) begin
                    // Memory full and the image still has not ended.
                    err_next   = 1'b1;
                    state_next = ERR;
                end else begin
                    state_next = LOAD;
                end
            end

            DONE: begin
                state_next = DONE;
            end

            ERR: begin
                state_next = ERR;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a default-size instance for the
// stream tests and an ADDR_W=2 instance for the overflow test. Expected
// writes are queued when stimulus is driven and popped when we is seen.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Default instance (ADDR_W = 6)
    logic        a_s_valid, a_s_ready, a_s_last;
    logic [7:0]  a_s_data;
    logic        a_we, a_cpu_reset, a_done, a_err;
    logic [5:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [6:0]  a_word_count;

    // Small instance (ADDR_W = 2)
    logic        b_s_valid, b_s_ready, b_s_last;
    logic [7:0]  b_s_data;
    logic        b_we, b_cpu_reset, b_done, b_err;
    logic [1:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [2:0]  b_word_count;

    imem_loader #(.ADDR_W(6)) dut_a (
        .clk(clk), .reset(reset),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_last(a_s_last),
        .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .cpu_reset(a_cpu_reset), .done(a_done), .err(a_err), .word_count(a_word_count)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .cpu_reset(b_cpu_reset), .done(b_done), .err(b_err), .word_count(b_word_count)
    );

    int errors = 0;
    int checks = 0;

    logic [37:0] q_a[$];
    logic [33:0] q_b[$];
    logic [37:0] exp_a;
    logic [33:0] exp_b;

    // Scoreboard for instance a: every strobe must match the next queued write.
    always @(negedge clk) begin
        if (reset === 1'b1 && a_we === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_write: got addr=%0d data=%08h, required no write", a_waddr, a_wdata);
            end else begin
                exp_a = q_a.pop_front();
                if ({a_waddr, a_wdata} !== exp_a) begin
                    errors++;
                    $display("FAIL a_write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             a_waddr, a_wdata, exp_a[37:32], exp_a[31:0]);
                end else begin
                    $display("a write addr=%0d data=%08h ok", a_waddr, a_wdata);
                end
            end
            checks++;
            if (a_s_ready !== 1'b0) begin
                errors++;
                $display("FAIL a_ready_in_write: got %b, required 0", a_s_ready);
            end
        end
    end

    // Scoreboard for instance b.
    always @(negedge clk) begin
        if (reset === 1'b1 && b_we === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_write: got addr=%0d data=%08h, required no write", b_waddr, b_wdata);
            end else begin
                exp_b = q_b.pop_front();
                if ({b_waddr, b_wdata} !== exp_b) begin
                    errors++;
                    $display("FAIL b_write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             b_waddr, b_wdata, exp_b[33:32], exp_b[31:0]);
                end else begin
                    $display("b write addr=%0d data=%08h ok", b_waddr, b_wdata);
                end
            end
        end
    end

    // Present one byte (at a negedge) and hold it until accepted.
    task automatic send(input bit sel, input logic [7:0] d, input bit last,
                        input int gap, output int waits);
        if (!sel) begin
            a_s_valid = 1'b1; a_s_data = d; a_s_last = last;
        end else begin
            b_s_valid = 1'b1; b_s_data = d; b_s_last = last;
        end
        waits = 0;
        while (((sel ? b_s_ready : a_s_ready) !== 1'b1) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %02h never accepted, required acceptance within 50 cycles", d);
        end
        @(negedge clk);
        if (!sel) begin
            a_s_valid = 1'b0; a_s_last = 1'b0;
        end else begin
            b_s_valid = 1'b0; b_s_last = 1'b0;
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        a_s_valid = 1'b0; a_s_last = 1'b0; a_s_data = 8'h00;
        b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({a_s_ready, a_we, a_waddr, a_wdata, a_cpu_reset, a_done, a_err, a_word_count} !==
            {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 7'd0}) begin
            errors++;
            $display("FAIL %s: got rdy=%b we=%b addr=%0d data=%08h cpu_rst=%b done=%b err=%b wc=%0d, required 0 0 0 00000000 1 0 0 0",
                     tag, a_s_ready, a_we, a_waddr, a_wdata, a_cpu_reset, a_done, a_err, a_word_count);
        end
    endtask

    task automatic check_final(input string tag, input bit e_done, input bit e_err,
                               input logic [6:0] e_wc);
        checks++;
        if ({a_done, a_cpu_reset, a_err, a_s_ready, a_word_count} !==
            {e_done, ~e_done, e_err, 1'b0, e_wc}) begin
            errors++;
            $display("FAIL %s: got done=%b cpu_rst=%b err=%b rdy=%b wc=%0d, required done=%b cpu_rst=%b err=%b rdy=0 wc=%0d",
                     tag, a_done, a_cpu_reset, a_err, a_s_ready, a_word_count,
                     e_done, ~e_done, e_err, e_wc);
        end
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d writes missing, required 0", tag, q_a.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_s_valid = 1'b0; a_s_last = 1'b0; a_s_data = 8'h00;
        b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        checks++;
        if ({b_cpu_reset, b_s_ready, b_word_count} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL b_reset_values: got cpu_rst=%b rdy=%b wc=%0d, required 1 0 0",
                     b_cpu_reset, b_s_ready, b_word_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_stream(input string tag, input int gap);
        logic [7:0] img [8];
        int w;
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C};
        apply_reset();
        q_a.push_back({6'd0, 32'h20080005});
        q_a.push_back({6'd1, 32'h2009000C});
        for (int i = 0; i < 8; i++) begin
            send(1'b0, img[i], (i == 7), gap, w);
            if (i == 4 && gap == 0) begin
                checks++;
                if (w !== 1) begin
                    errors++;
                    $display("FAIL %s_hold_in_write: byte 5 waited %0d cycles, required 1", tag, w);
                end
            end
            if (i == 1) begin
                checks++;
                if (a_s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready_in_load: got %b, required 1", tag, a_s_ready);
                end
            end
        end
        repeat (2) @(negedge clk);
        check_final(tag, 1'b1, 1'b0, 7'd2);
    endtask

    task automatic test_partial();
        int w;
        apply_reset();
        q_a.push_back({6'd0, 32'h01020304});
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 8'(i + 1), (i == 5), 0, w);
        end
        repeat (3) @(negedge clk);
        check_final("partial", 1'b0, 1'b1, 7'd1);
    endtask

    task automatic test_overflow();
        int w;
        logic [31:0] word;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            word = 32'h11111111 * (k + 1);
            q_b.push_back({2'(k), word});
            for (int j = 3; j >= 0; j--) begin
                send(1'b1, word[j*8 +: 8], 1'b0, 0, w);
            end
        end
        b_s_valid = 1'b1; b_s_data = 8'hAA; b_s_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (b_s_ready !== 1'b0) begin
                errors++;
                $display("FAIL overflow_ready: cycle %0d got %b, required 0", c, b_s_ready);
            end
        end
        b_s_valid = 1'b0;
        checks++;
        if ({b_err, b_done, b_cpu_reset, b_word_count} !== {1'b1, 1'b0, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL overflow_final: got err=%b done=%b cpu_rst=%b wc=%0d, required 1 0 1 4",
                     b_err, b_done, b_cpu_reset, b_word_count);
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL overflow_pending: got %0d writes missing, required 0", q_b.size());
        end
    endtask

    task automatic test_midreset();
        int w;
        logic [7:0] img [10];
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        apply_reset();
        q_a.push_back({6'd0, 32'h11223344});
        q_a.push_back({6'd1, 32'h55667788});
        for (int i = 0; i < 10; i++) send(1'b0, img[i], 1'b0, 0, w);
        #2 reset = 1'b0;
        #1 check_reset_values("midreset_values");
        @(negedge clk);
        reset = 1'b1;
        q_a.push_back({6'd0, 32'hDEADBEEF});
        send(1'b0, 8'hDE, 1'b0, 0, w);
        send(1'b0, 8'hAD, 1'b0, 0, w);
        send(1'b0, 8'hBE, 1'b0, 0, w);
        send(1'b0, 8'hEF, 1'b1, 0, w);
        repeat (2) @(negedge clk);
        check_final("reload", 1'b1, 1'b0, 7'd1);
    endtask

    task automatic test_after_done();
        a_s_valid = 1'b1; a_s_data = 8'h55; a_s_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({a_s_ready, a_we, a_done, a_cpu_reset, a_err, a_word_count, a_waddr, a_wdata} !==
                {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 6'd0, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL after_done: cycle %0d got rdy=%b we=%b done=%b cpu_rst=%b err=%b wc=%0d addr=%0d data=%08h, required 0 0 1 0 0 1 0 deadbeef",
                         c, a_s_ready, a_we, a_done, a_cpu_reset, a_err, a_word_count, a_waddr, a_wdata);
            end
        end
        a_s_valid = 1'b0; a_s_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream("held", 0);
        test_stream("gapped", 3);
        test_partial();
        test_overflow();
        test_midreset();
        test_after_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
